muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide responder for the ARM core's Division / Multiplication / DivMode request outputs.
- Accepts one operation per request and computes it over 32 iteration cycles.
- Returns low and high result words with a one-cycle done pulse, so the core can stall on busy and write back on done.
- Sits beside the datapath and is fed by the same SrcA/SrcB operand buses as the ALU.

Parameters:
- WIDTH, 32, operand width; results are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- start  in  1  request strobe from the core.
- Division  in  1  request is a divide.
- Multiplication  in  1  request is a multiply.
- DivMode  in  1  1 = signed operands, 0 = unsigned; applies to both operations.
- SrcA  in  WIDTH  multiplicand or dividend.
- SrcB  in  WIDTH  multiplier or divisor.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results valid in this cycle.
- ResultLo  out  WIDTH  product low word or quotient.
- ResultHi  out  WIDTH  product high word or remainder.
- DivZero  out  1  last divide had SrcB == 0.

Behaviour:
- Reset (reset = 0, at any time, including mid-operation):
  - state = IDLE, counter = 0.
  - busy, done, DivZero = 0; ResultLo, ResultHi = 0.
  - The in-flight operation is discarded.
- Accept condition: start = 1, exactly one of Division / Multiplication = 1, and state is IDLE or DONE.
  - SrcA, SrcB, DivMode and the op are latched at that edge.
  - All other cases are ignored with no state change: start during RUN/FIX, both op bits set, or neither op bit set.
- States: IDLE -> RUN (on accept) -> FIX -> DONE -> IDLE, or DONE -> RUN on a back-to-back accept.
- Latency: start sampled in cycle 0; RUN occupies cycles 1..32; FIX is cycle 33; DONE is cycle 34 with done = 1. Latency is fixed at 34 for every op, including divide-by-zero.
- busy = 1 in RUN and FIX, 0 otherwise.
- Signed mode: operands are converted to magnitudes at accept; the result signs are recorded and applied in FIX.
- Multiply:
  - RUN performs shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - {ResultHi, ResultLo} = full 64-bit product; two's complement in signed mode.
- Divide:
  - RUN performs restoring division, one quotient bit per cycle.
  - The quotient truncates toward zero; the remainder sign follows the dividend.
  - Invariant: SrcA = q*SrcB + r.
- Divide by zero: ResultLo = all ones, ResultHi = SrcA unchanged, DivZero = 1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): ResultLo = 0x80000000, ResultHi = 0, DivZero = 0.
- DivZero updates only at FIX of a divide; a multiply clears it.
- ResultLo/ResultHi update only at the FIX->DONE edge and hold until the next FIX. They are not disturbed during RUN.
- The counter runs 0..WIDTH-1 in RUN; FIX is entered when the counter reaches WIDTH-1.

Decomposition:
- Shared package muldiv_pkg holds:
  - the state enum: IDLE, RUN, FIX, DONE;
  - the op encoding constants: OP_MUL, OP_DIV;
  - the DIV0_QUOT all-ones constant;
  - the INT_MIN constant.
- One sub-module, muldiv_sign_fix: combinational conditional two's-complement negation. It is instantiated at operand capture (absolute value) and at FIX (result sign).
- The counter, FSM and accumulator stay in muldiv_unit.

Test Plan:
- Unsigned multiply, DivMode = 0: SrcA = 0xFFFFFFFF, SrcB = 0x00000002 -> done in cycle 34; ResultHi = 0x00000001, ResultLo = 0xFFFFFFFE; busy high for cycles 1..33.
- Signed divide, DivMode = 1: SrcA = 0xFFFFFFF9 (-7), SrcB = 2 -> ResultLo = 0xFFFFFFFD (-3), ResultHi = 0xFFFFFFFF (-1), DivZero = 0.
- Divide by zero: SrcA = 0x12345678, SrcB = 0 -> ResultLo = 0xFFFFFFFF, ResultHi = 0x12345678, DivZero = 1; a following multiply 3*4 -> ResultLo = 12, DivZero = 0.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> ResultLo = 0x80000000, ResultHi = 0.
- Request rules:
  - start pulsed in cycle 10 of a running multiply is ignored; the result is unchanged.
  - start with both Division and Multiplication = 1 is ignored; busy stays 0.
  - start asserted in the DONE cycle is accepted; the next done arrives 34 cycles later.
- Reset = 0 asserted asynchronously in cycle 15 of a divide -> busy, done, ResultLo, ResultHi and DivZero go to 0 immediately; after release, a new 100/7 gives ResultLo = 14, ResultHi = 2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_DEF_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [DATA_W-1:0] DIV0_QUOT = '1;
  localparam logic [DATA_W-1:0] INT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the core (master) and the muldiv unit (slave).
interface muldiv_if #(
  parameter int unsigned WIDTH = muldiv_pkg::DATA_W
);
  logic             start;
  logic             Division;
  logic             Multiplication;
  logic             DivMode;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic             DivZero;

  modport master (
    output start, Division, Multiplication, DivMode, SrcA, SrcB,
    input  busy, done, ResultLo, ResultHi, DivZero
  );

  modport slave (
    input  start, Division, Multiplication, DivMode, SrcA, SrcB,
    output busy, done, ResultLo, ResultHi, DivZero
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result signs.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y_c
);

  assign y_c = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider with fixed 34-cycle latency.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = CNT_DEF_W
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   addend_q;
  logic [WIDTH-1:0]   raw_a_q;
  logic               op_q, neg_q, sa_q, bzero_q, ovf_q;
  logic               busy_q, done_q, divzero_q;
  logic [WIDTH-1:0]   res_lo_q, res_hi_q;

  logic               accept_c, sa_c, sb_c, ovf_c;
  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [WIDTH:0]     mul_sum_c, rem_sh_c;
  logic [WIDTH-1:0]   rem_sub_c, rem_nxt_c;
  logic               ge_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quot_c, rem_c;

  assign accept_c = bus.start && (bus.Division ^ bus.Multiplication) &&
                    ((state_q == IDLE) || (state_q == DONE));
  assign sa_c  = bus.DivMode & bus.SrcA[WIDTH-1];
  assign sb_c  = bus.DivMode & bus.SrcB[WIDTH-1];
  assign ovf_c = bus.DivMode && (bus.SrcA == WIDTH'(INT_MIN)) && (&bus.SrcB);

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.x(bus.SrcA), .neg(sa_c), .y_c(mag_a_c));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.x(bus.SrcB), .neg(sb_c), .y_c(mag_b_c));

  // One step of each algorithm; acc holds {hi, lo} for multiply and {rem, quot} for divide
  assign mul_sum_c = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (acc_q[0] ? addend_q : {WIDTH{1'b0}})};
  assign rem_sh_c  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge_c      = rem_sh_c >= {1'b0, addend_q};
  assign rem_sub_c = rem_sh_c[WIDTH-1:0] - addend_q;
  assign rem_nxt_c = ge_c ? rem_sub_c : rem_sh_c[WIDTH-1:0];

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.x(acc_q), .neg(neg_q), .y_c(prod_c));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quot (.x(acc_q[WIDTH-1:0]), .neg(neg_q), .y_c(quot_c));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (.x(acc_q[2*WIDTH-1:WIDTH]), .neg(sa_q), .y_c(rem_c));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = accept_c ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      addend_q  <= '0;
      raw_a_q   <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      bzero_q   <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN) || (state_d == FIX);
      done_q  <= (state_d == DONE);

      if (accept_c) begin
        cnt_q    <= '0;
        op_q     <= bus.Division ? OP_DIV : OP_MUL;
        addend_q <= bus.Division ? mag_b_c : mag_a_c;
        acc_q    <= {{WIDTH{1'b0}}, (bus.Division ? mag_a_c : mag_b_c)};
        raw_a_q  <= bus.SrcA;
        neg_q    <= sa_c ^ sb_c;
        sa_q     <= sa_c;
        bzero_q  <= (bus.SrcB == '0);
        ovf_q    <= ovf_c;
      end else if (state_q == RUN) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        acc_q <= (op_q == OP_DIV) ? {rem_nxt_c, acc_q[WIDTH-2:0], ge_c}
                                  : {mul_sum_c, acc_q[WIDTH-1:1]};
      end

      // Results and DivZero change only on the FIX->DONE edge
      if (state_q == FIX) begin
        if (op_q == OP_MUL) begin
          {res_hi_q, res_lo_q} <= prod_c;
          divzero_q            <= 1'b0;
        end else if (bzero_q) begin
          res_lo_q  <= WIDTH'(DIV0_QUOT);
          res_hi_q  <= raw_a_q;
          divzero_q <= 1'b1;
        end else if (ovf_q) begin
          res_lo_q  <= WIDTH'(INT_MIN);
          res_hi_q  <= '0;
          divzero_q <= 1'b0;
        end else begin
          res_lo_q  <= quot_c;
          res_hi_q  <= rem_c;
          divzero_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ResultLo = res_lo_q;
  assign bus.ResultHi = res_hi_q;
  assign bus.DivZero  = divzero_q;

endmodule
